// File: rtl/rast_pkg.sv
// Shared types and widths for the triangle rasteriser: FSM states, edge/depth
// accumulator widths and the edge-function coefficient record.
package rast_pkg;

  // Edge terms are sized for coordinates up to this many bits (x and y); the
  // exact need is X_PIXEL_SIZE+Y_PIXEL_SIZE+3, so this is the upper bound.
  localparam int MAX_COORD_BITS = 8;
  localparam int EDGE_W         = 2 * MAX_COORD_BITS + 3;
  localparam int ZACC_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ORIGIN,
    SCAN,
    DONE
  } state_e;

  typedef struct packed {
    logic signed [EDGE_W-1:0] a;
    logic signed [EDGE_W-1:0] b;
    logic signed [EDGE_W-1:0] c;
  } edge_coef_t;

endpackage

// File: rtl/fragment_gen_if.sv
// Triangle-in / fragment-out handshake bundle of the fragment generator.
interface fragment_gen_if #(
  parameter int X_RES  = 4,
  parameter int Y_RES  = 4,
  parameter int Z_SIZE = 8,
  parameter int Z_FRAC = 8
);
  localparam int X_PIXEL_SIZE = $clog2(X_RES);
  localparam int Y_PIXEL_SIZE = $clog2(Y_RES);
  localparam int ZW           = Z_SIZE + Z_FRAC;

  logic                     tri_valid_i;
  logic                     tri_ready_o;
  logic [X_PIXEL_SIZE-1:0]  v0_x_i, v1_x_i, v2_x_i;
  logic [Y_PIXEL_SIZE-1:0]  v0_y_i, v1_y_i, v2_y_i;
  logic [ZW-1:0]            z0_i;
  logic signed [ZW:0]       dzdx_i, dzdy_i;
  logic                     frag_valid_o;
  logic                     frag_ready_i;
  logic [X_PIXEL_SIZE-1:0]  frag_x_o;
  logic [Y_PIXEL_SIZE-1:0]  frag_y_o;
  logic [Z_SIZE-1:0]        frag_z_o;
  logic                     tri_done_o;

  modport master (
    output tri_valid_i, v0_x_i, v1_x_i, v2_x_i, v0_y_i, v1_y_i, v2_y_i,
    output z0_i, dzdx_i, dzdy_i, frag_ready_i,
    input  tri_ready_o, frag_valid_o, frag_x_o, frag_y_o, frag_z_o, tri_done_o
  );

  modport slave (
    input  tri_valid_i, v0_x_i, v1_x_i, v2_x_i, v0_y_i, v1_y_i, v2_y_i,
    input  z0_i, dzdx_i, dzdy_i, frag_ready_i,
    output tri_ready_o, frag_valid_o, frag_x_o, frag_y_o, frag_z_o, tri_done_o
  );
endinterface

// File: rtl/edge_step.sv
// One incremental edge function: keeps the current pixel value and the value
// at the start of the current row.
module edge_step #(
  parameter int DATA_W = 19
) (
  input  logic                     clk_i,
  input  logic                     load,
  input  logic                     step_x,
  input  logic                     step_row,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] init,
  output logic signed [DATA_W-1:0] value
);

  logic signed [DATA_W-1:0] row_q;
  logic signed [DATA_W-1:0] cur_q;

  always_ff @(posedge clk_i) begin
    if (load) begin
      row_q <= init;
      cur_q <= init;
    end else if (step_row) begin
      row_q <= row_q + b;
      cur_q <= row_q + b;
    end else if (step_x) begin
      cur_q <= cur_q + a;
    end
  end

  assign value = cur_q;

endmodule

// File: rtl/fragment_gen.sv
// Bounding-box scan rasteriser: accepts one triangle, emits covered pixels in
// raster order with interpolated, clamped depth, then pulses tri_done_o.
module fragment_gen
  import rast_pkg::*;
#(
  parameter int X_RES  = 4,
  parameter int Y_RES  = 4,
  parameter int Z_SIZE = 8,
  parameter int Z_FRAC = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fragment_gen_if.slave bus
);

  localparam int X_PIXEL_SIZE = $clog2(X_RES);
  localparam int Y_PIXEL_SIZE = $clog2(Y_RES);
  localparam int XW           = X_PIXEL_SIZE;
  localparam int YW           = Y_PIXEL_SIZE;
  localparam int ZW           = Z_SIZE + Z_FRAC;

  typedef logic signed [EDGE_W-1:0] edge_t;
  typedef logic signed [ZACC_W-1:0] zacc_t;

  state_e              state;
  logic                ready_q, done_q, fvalid_q, scan_end_q;
  logic [XW-1:0]       fx_q, cx_q;
  logic [YW-1:0]       fy_q, cy_q;
  logic [Z_SIZE-1:0]   fz_q;

  logic [XW-1:0]       v0x_q, v1x_q, v2x_q, minx_q, maxx_q, minx_c, maxx_c;
  logic [YW-1:0]       v0y_q, v1y_q, v2y_q, miny_q, maxy_q, miny_c, maxy_c;
  logic [ZW-1:0]       z0_q;
  logic signed [ZW:0]  dzdx_q, dzdy_q;
  edge_coef_t          coef_raw [3];
  edge_coef_t          coef_q   [3];
  edge_t               ev_origin [3];
  edge_t               ev       [3];
  edge_t               area;
  zacc_t               z_origin, zrow_q, zcur_q;

  logic accept, slot_free, advance, x_end, y_end, step_x, step_row, covered, load_edges;

  function automatic edge_t sx(input logic [XW-1:0] v);
    return edge_t'(v);
  endfunction

  function automatic edge_t sy(input logic [YW-1:0] v);
    return edge_t'(v);
  endfunction

  function automatic edge_coef_t make_coef(input logic [XW-1:0] xi, input logic [YW-1:0] yi,
                                           input logic [XW-1:0] xj, input logic [YW-1:0] yj);
    edge_coef_t r;
    r.a = sy(yi) - sy(yj);
    r.b = sx(xj) - sx(xi);
    r.c = sx(xi) * sy(yj) - sx(xj) * sy(yi);
    return r;
  endfunction

  function automatic edge_coef_t flip_coef(input edge_coef_t c, input logic flip);
    edge_coef_t r;
    r.a = flip ? -c.a : c.a;
    r.b = flip ? -c.b : c.b;
    r.c = flip ? -c.c : c.c;
    return r;
  endfunction

  // Drop the fractional depth bits (floor) and saturate to the depth range.
  function automatic logic [Z_SIZE-1:0] clamp_z(input zacc_t acc);
    zacc_t s;
    s = acc >>> Z_FRAC;
    if (s[ZACC_W-1]) return '0;
    if (s > zacc_t'((1 << Z_SIZE) - 1)) return '1;
    return s[Z_SIZE-1:0];
  endfunction

  always_comb begin
    coef_raw[0] = make_coef(v0x_q, v0y_q, v1x_q, v1y_q);
    coef_raw[1] = make_coef(v1x_q, v1y_q, v2x_q, v2y_q);
    coef_raw[2] = make_coef(v2x_q, v2y_q, v0x_q, v0y_q);
    area = edge_t'(coef_raw[0].a) * sx(v2x_q) + edge_t'(coef_raw[0].b) * sy(v2y_q)
         + edge_t'(coef_raw[0].c);

    minx_c = (v0x_q < v1x_q) ? v0x_q : v1x_q;
    minx_c = (v2x_q < minx_c) ? v2x_q : minx_c;
    maxx_c = (v0x_q > v1x_q) ? v0x_q : v1x_q;
    maxx_c = (v2x_q > maxx_c) ? v2x_q : maxx_c;
    miny_c = (v0y_q < v1y_q) ? v0y_q : v1y_q;
    miny_c = (v2y_q < miny_c) ? v2y_q : miny_c;
    maxy_c = (v0y_q > v1y_q) ? v0y_q : v1y_q;
    maxy_c = (v2y_q > maxy_c) ? v2y_q : maxy_c;

    for (int i = 0; i < 3; i++) begin
      ev_origin[i] = edge_t'(coef_q[i].a) * sx(minx_q) + edge_t'(coef_q[i].b) * sy(miny_q)
                   + edge_t'(coef_q[i].c);
    end
    z_origin = zacc_t'(z0_q)
             + zacc_t'(dzdx_q) * (zacc_t'(minx_q) - zacc_t'(v0x_q))
             + zacc_t'(dzdy_q) * (zacc_t'(miny_q) - zacc_t'(v0y_q));

    accept     = (state == IDLE) && ready_q && bus.tri_valid_i;
    load_edges = (state == ORIGIN);
    slot_free  = !fvalid_q || bus.frag_ready_i;
    advance    = (state == SCAN) && !scan_end_q && slot_free;
    x_end      = (cx_q == maxx_q);
    y_end      = (cy_q == maxy_q);
    step_x     = advance && !x_end;
    step_row   = advance && x_end && !y_end;
    covered    = !ev[0][EDGE_W-1] && !ev[1][EDGE_W-1] && !ev[2][EDGE_W-1];
  end

  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_step #(.DATA_W(EDGE_W)) u_edge (
      .clk_i    (clk_i),
      .load     (load_edges),
      .step_x   (step_x),
      .step_row (step_row),
      .a        (coef_q[i].a),
      .b        (coef_q[i].b),
      .init     (ev_origin[i]),
      .value    (ev[i])
    );
  end

  // Triangle datapath: capture, setup coefficients/bbox, depth stepping.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      v0x_q  <= bus.v0_x_i;
      v1x_q  <= bus.v1_x_i;
      v2x_q  <= bus.v2_x_i;
      v0y_q  <= bus.v0_y_i;
      v1y_q  <= bus.v1_y_i;
      v2y_q  <= bus.v2_y_i;
      z0_q   <= bus.z0_i;
      dzdx_q <= bus.dzdx_i;
      dzdy_q <= bus.dzdy_i;
    end
    if (state == SETUP) begin
      for (int i = 0; i < 3; i++) coef_q[i] <= flip_coef(coef_raw[i], area[EDGE_W-1]);
      minx_q <= minx_c;
      maxx_q <= maxx_c;
      miny_q <= miny_c;
      maxy_q <= maxy_c;
    end
    if (load_edges) begin
      zrow_q <= z_origin;
      zcur_q <= z_origin;
    end else if (step_row) begin
      zrow_q <= zrow_q + zacc_t'(dzdy_q);
      zcur_q <= zrow_q + zacc_t'(dzdy_q);
    end else if (step_x) begin
      zcur_q <= zcur_q + zacc_t'(dzdx_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      fvalid_q   <= 1'b0;
      scan_end_q <= 1'b0;
      fx_q       <= '0;
      fy_q       <= '0;
      fz_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= !accept;
          if (accept) state <= SETUP;
        end
        SETUP: begin
          if (area == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= ORIGIN;
          end
        end
        ORIGIN: begin
          state      <= SCAN;
          cx_q       <= minx_q;
          cy_q       <= miny_q;
          scan_end_q <= 1'b0;
        end
        SCAN: begin
          // The output register is a one-deep slot: a new pixel is taken
          // only once the fragment it holds has been accepted.
          if (scan_end_q) begin
            if (slot_free) begin
              fvalid_q <= 1'b0;
              state    <= DONE;
              done_q   <= 1'b1;
            end
          end else if (slot_free) begin
            fvalid_q <= covered;
            if (covered) begin
              fx_q <= cx_q;
              fy_q <= cy_q;
              fz_q <= clamp_z(zcur_q);
            end
            if (x_end) begin
              cx_q <= minx_q;
              if (y_end) scan_end_q <= 1'b1;
              else       cy_q       <= cy_q + 1'b1;
            end else begin
              cx_q <= cx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tri_ready_o  = ready_q;
  assign bus.frag_valid_o = fvalid_q;
  assign bus.frag_x_o     = fx_q;
  assign bus.frag_y_o     = fy_q;
  assign bus.frag_z_o     = fz_q;
  assign bus.tri_done_o   = done_q;

endmodule
